// File: rtl/rf_access_ctrl_pkg.sv
// Shared definitions for the register-file access controller.
//   state_t  : controller FSM states, 2-bit encoding
//   REG_ZERO : hard-wired zero register, never written
//   LAST_REG : highest register touched by the clear sequence
package rf_access_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CLEAR  = 2'd1;
    localparam logic [1:0] ST_DBG_RD = 2'd2;
    localparam logic [1:0] ST_ACK    = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        CLEAR  = ST_CLEAR,
        DBG_RD = ST_DBG_RD,
        ACK    = ST_ACK
    } state_t;

    localparam int REG_ZERO = 0;
    localparam int LAST_REG = 31;

endpackage

// File: rtl/rf_access_ctrl_if.sv
// Bus bundle between the CPU writeback / debug host / clear trigger on one side,
// the access controller in the middle, and the RegisterFile ports.
//   slave  : the controller (rf_access_ctrl)
//   master : everything around it (CPU, debug host, RegisterFile)
//
// Debug handshake: dbg_req is a level held high (with dbg_we, dbg_addr and
// dbg_wdata stable) until dbg_ack pulses for exactly one cycle; the requester
// drops dbg_req in the ack cycle, otherwise a new transaction starts. dbg_rdata
// is only meaningful in the ack cycle of a read. There is no backpressure on
// dbg_ack. The CPU side has no request handshake: cpu_stall means "this cycle's
// writeback was not taken, hold PC and present it again".
//
// fsm_state exposes the controller state for observation.
interface rf_access_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    import rf_access_ctrl_pkg::*;

    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_waddr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    logic              rf_RegWrite;
    logic [ADDR_W-1:0] rf_WriteReg;
    logic [DATA_W-1:0] rf_WriteData;
    logic [ADDR_W-1:0] rf_regNo;
    logic [DATA_W-1:0] rf_val;

    state_t            fsm_state;

    modport slave (
        input  cpu_we, cpu_waddr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  clr_req,
        input  rf_val,
        output cpu_stall,
        output dbg_ack, dbg_rdata,
        output clr_busy, clr_done,
        output rf_RegWrite, rf_WriteReg, rf_WriteData, rf_regNo,
        output fsm_state
    );

    modport master (
        output cpu_we, cpu_waddr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output clr_req,
        output rf_val,
        input  cpu_stall,
        input  dbg_ack, dbg_rdata,
        input  clr_busy, clr_done,
        input  rf_RegWrite, rf_WriteReg, rf_WriteData, rf_regNo,
        input  fsm_state
    );

endinterface

// File: rtl/rf_access_ctrl_wport_mux.sv
// Combinational priority mux for the single RegisterFile write port.
// Ports:
//   gnt_clr, gnt_dbg, gnt_cpu : grant one-hots (clr > dbg > cpu if several set)
//   clr_addr                  : clear sequencer address, data is always zero
//   dbg_addr, dbg_wdata       : debug write source
//   cpu_waddr, cpu_wdata      : CPU writeback source
//   rf_RegWrite/WriteReg/WriteData : RegisterFile write port
// A granted write to r0 is turned into "no write" so r0 stays zero.
module rf_wport_mux
    import rf_access_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              gnt_clr,
    input  logic              gnt_dbg,
    input  logic              gnt_cpu,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic [ADDR_W-1:0] cpu_waddr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              rf_RegWrite,
    output logic [ADDR_W-1:0] rf_WriteReg,
    output logic [DATA_W-1:0] rf_WriteData
);

    always_comb begin
        rf_RegWrite  = 1'b0;
        rf_WriteReg  = '0;
        rf_WriteData = '0;
        if (gnt_clr) begin
            rf_RegWrite  = 1'b1;
            rf_WriteReg  = clr_addr;
            rf_WriteData = '0;
        end else if (gnt_dbg) begin
            rf_RegWrite  = (dbg_addr != ADDR_W'(REG_ZERO));
            rf_WriteReg  = dbg_addr;
            rf_WriteData = dbg_wdata;
        end else if (gnt_cpu) begin
            rf_RegWrite  = (cpu_waddr != ADDR_W'(REG_ZERO));
            rf_WriteReg  = cpu_waddr;
            rf_WriteData = cpu_wdata;
        end
    end

endmodule

// File: rtl/rf_access_ctrl.sv
// RegisterFile write-port owner and debug-read path.
// Arbitrates the single write port between CPU writeback, a debug/loader host
// and a clear sequencer that zeroes r1..r31, and stalls the CPU whenever it
// loses the port.
// Ports:
//   clk     : system clock, rising edge
//   startin : asynchronous active-high reset
//   bus     : rf_access_ctrl_if slave modport (CPU, debug, clear, RegisterFile)
module rf_access_ctrl
    import rf_access_ctrl_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DBG_MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          startin,
    rf_access_ctrl_if.slave bus
);

    localparam int WAIT_W = $clog2(DBG_MAX_WAIT + 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] clr_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              dbg_ack_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic              clr_done_q;

    logic in_idle, idle_free, dbg_wr_pend, dbg_rd_pend, clr_last;
    logic forced, gnt_clr, gnt_dbg, gnt_cpu;

    always_comb begin
        in_idle     = (state == IDLE);
        // IDLE and no clear request: the only place debug work is accepted
        idle_free   = in_idle && !bus.clr_req;
        dbg_wr_pend = bus.dbg_req && bus.dbg_we;
        dbg_rd_pend = bus.dbg_req && !bus.dbg_we;
        clr_last    = (clr_cnt == ADDR_W'(LAST_REG));

        // A debug write starved long enough takes the port from the CPU
        forced  = idle_free && dbg_wr_pend && (wait_cnt == WAIT_W'(DBG_MAX_WAIT));
        gnt_clr = (state == CLEAR);
        gnt_dbg = idle_free && dbg_wr_pend && (forced || !bus.cpu_we);
        // CPU owns the port in every state except CLEAR or a forced debug cycle
        gnt_cpu = bus.cpu_we && !gnt_clr && !forced;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.clr_req)      state_nx = CLEAR;
                else if (gnt_dbg)     state_nx = ACK;
                else if (dbg_rd_pend) state_nx = DBG_RD;
            end
            CLEAR:   if (clr_last) state_nx = IDLE;
            DBG_RD:  state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            state       <= IDLE;
            clr_cnt     <= ADDR_W'(1);
            wait_cnt    <= '0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
            clr_done_q  <= 1'b0;
        end else begin
            state      <= state_nx;
            dbg_ack_q  <= (state_nx == ACK);
            clr_done_q <= gnt_clr && clr_last;

            if (gnt_clr)
                clr_cnt <= clr_last ? ADDR_W'(1) : clr_cnt + ADDR_W'(1);

            // RegisterFile read is registered, so rf_val here reflects the
            // register as it was at the accept edge (pre-write on a collision).
            if (state == DBG_RD)
                dbg_rdata_q <= bus.rf_val;

            if (gnt_dbg)
                wait_cnt <= '0;
            else if (idle_free && dbg_wr_pend && bus.cpu_we &&
                     wait_cnt != WAIT_W'(DBG_MAX_WAIT))
                wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    rf_wport_mux #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_wport_mux (
        .gnt_clr     (gnt_clr),
        .gnt_dbg     (gnt_dbg),
        .gnt_cpu     (gnt_cpu),
        .clr_addr    (clr_cnt),
        .dbg_addr    (bus.dbg_addr),
        .dbg_wdata   (bus.dbg_wdata),
        .cpu_waddr   (bus.cpu_waddr),
        .cpu_wdata   (bus.cpu_wdata),
        .rf_RegWrite (bus.rf_RegWrite),
        .rf_WriteReg (bus.rf_WriteReg),
        .rf_WriteData(bus.rf_WriteData)
    );

    assign bus.cpu_stall = gnt_clr || forced;
    assign bus.clr_busy  = gnt_clr;
    assign bus.rf_regNo  = bus.dbg_req ? bus.dbg_addr : '0;
    assign bus.dbg_ack   = dbg_ack_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.clr_done  = clr_done_q;
    assign bus.fsm_state = state;

endmodule

// File: tb/tb_rf_access_ctrl.sv
module tb_rf_access_ctrl;
    import rf_access_ctrl_pkg::*;

    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 5;
    localparam int DBG_MAX_WAIT = 8;
    localparam int NREG         = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic startin;
    always #5 clk = ~clk;

    rf_access_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_access_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DBG_MAX_WAIT(DBG_MAX_WAIT)
    ) dut (
        .clk    (clk),
        .startin(startin),
        .bus    (bus)
    );

    // RegisterFile: write on rising edge, registered read of regNo, r0 = 0
    logic [DATA_W-1:0] rf_mem [NREG];
    always @(posedge clk) begin
        if (bus.rf_RegWrite && bus.rf_WriteReg != 5'd0)
            rf_mem[bus.rf_WriteReg] <= bus.rf_WriteData;
        bus.rf_val <= (bus.rf_regNo == 5'd0) ? '0 : rf_mem[bus.rf_regNo];
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_rf [NREG];   // architectural view of the register file
    logic [DATA_W-1:0] exp_q [$];       // expected debug read data in issue order

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.cpu_we = 1'b0; bus.cpu_waddr = '0; bus.cpu_wdata = '0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        bus.clr_req = 1'b0;
    endtask

    task automatic model_clear(input int upto);
        for (int r = 1; r <= upto; r++) exp_rf[r] = '0;
    endtask

    // Full debug transaction starting in IDLE; lat = cycles from accept to ack
    task automatic do_dbg(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata,
                          output int lat, output logic [DATA_W-1:0] rdata);
        bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
        lat = -1; rdata = '0;
        for (int i = 0; i < 64; i++) begin
            settle();
            if (bus.dbg_ack) begin lat = i; rdata = bus.dbg_rdata; break; end
            step();
        end
        step();
        bus.dbg_req = 1'b0;
        if (we && addr != 5'd0) exp_rf[addr] = wdata;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        startin = 1'b1;
        settle();
        n_checks++;
        if ({bus.fsm_state, bus.cpu_stall, bus.clr_busy, bus.rf_RegWrite, bus.dbg_ack, bus.clr_done}
            !== {IDLE, 5'b0}) begin
            n_fail++;
            $display("FAIL reset_ctrl: got state=%0d stall=%b busy=%b we=%b ack=%b done=%b exp idle/zeros",
                     bus.fsm_state, bus.cpu_stall, bus.clr_busy, bus.rf_RegWrite, bus.dbg_ack, bus.clr_done);
        end
        n_checks++;
        if (bus.dbg_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h exp 0", bus.dbg_rdata);
        end
        step();
        startin = 1'b0;
        step();
    endtask

    task automatic test_clear();
        int lat;
        logic [DATA_W-1:0] rd;
        bus.cpu_we = 1'b1; bus.cpu_waddr = 5'd5; bus.cpu_wdata = 32'hDEADBEEF;
        step();
        exp_rf[5] = 32'hDEADBEEF;
        bus.cpu_we = 1'b0;
        bus.clr_req = 1'b1;
        settle();
        n_checks++;
        if (bus.clr_busy !== 1'b0) begin n_fail++; $display("FAIL clr_idle_busy: got %b exp 0", bus.clr_busy); end
        step();
        bus.clr_req = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            settle();
            n_checks++;
            if ({bus.rf_RegWrite, bus.rf_WriteReg, bus.rf_WriteData, bus.cpu_stall, bus.clr_busy}
                !== {1'b1, 5'(i), 32'h0, 1'b1, 1'b1}) begin
                n_fail++;
                $display("FAIL clr_cycle%0d: got we=%b reg=%0d data=%h stall=%b busy=%b exp 1/%0d/0/1/1",
                         i, bus.rf_RegWrite, bus.rf_WriteReg, bus.rf_WriteData, bus.cpu_stall, bus.clr_busy, i);
            end
            step();
        end
        model_clear(31);
        settle();
        n_checks++;
        if ({bus.clr_done, bus.clr_busy, bus.rf_RegWrite, bus.cpu_stall} !== 4'b1000) begin
            n_fail++;
            $display("FAIL clr_done_pulse: got done=%b busy=%b we=%b stall=%b exp 1/0/0/0",
                     bus.clr_done, bus.clr_busy, bus.rf_RegWrite, bus.cpu_stall);
        end
        step(); settle();
        n_checks++;
        if (bus.clr_done !== 1'b0) begin n_fail++; $display("FAIL clr_done_width: got %b exp 0", bus.clr_done); end
        step();
        do_dbg(1'b0, 5'd5, '0, lat, rd);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL clr_read_lat: got %0d exp 2", lat); end
        n_checks++;
        if (rd !== exp_rf[5]) begin n_fail++; $display("FAIL clr_read_r5: got %h exp %h", rd, exp_rf[5]); end
    endtask

    task automatic test_cpu_write();
        int lat;
        logic [DATA_W-1:0] rd;
        bus.cpu_we = 1'b1; bus.cpu_waddr = 5'd3; bus.cpu_wdata = 32'h12345678;
        settle();
        n_checks++;
        if ({bus.rf_RegWrite, bus.rf_WriteReg, bus.rf_WriteData, bus.cpu_stall}
            !== {1'b1, 5'd3, 32'h12345678, 1'b0}) begin
            n_fail++;
            $display("FAIL cpu_wr: got we=%b reg=%0d data=%h stall=%b exp 1/3/12345678/0",
                     bus.rf_RegWrite, bus.rf_WriteReg, bus.rf_WriteData, bus.cpu_stall);
        end
        step();
        exp_rf[3] = 32'h12345678;
        bus.cpu_waddr = 5'd0; bus.cpu_wdata = 32'hFFFF0000;
        settle();
        n_checks++;
        if ({bus.rf_RegWrite, bus.cpu_stall} !== 2'b00) begin
            n_fail++; $display("FAIL cpu_wr_r0: got we=%b stall=%b exp 0/0", bus.rf_RegWrite, bus.cpu_stall);
        end
        step();
        bus.cpu_we = 1'b0;
        do_dbg(1'b0, 5'd3, '0, lat, rd);
        n_checks++;
        if (rd !== exp_rf[3]) begin n_fail++; $display("FAIL cpu_wr_readback: got %h exp %h", rd, exp_rf[3]); end
    endtask

    task automatic test_dbg_write_read();
        int lat;
        logic [DATA_W-1:0] rd;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 5'd7; bus.dbg_wdata = 32'hA5A5A5A5;
        settle();
        n_checks++;
        if ({bus.rf_RegWrite, bus.rf_WriteReg, bus.rf_WriteData, bus.cpu_stall, bus.dbg_ack}
            !== {1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL dbg_wr_grant: got we=%b reg=%0d data=%h stall=%b ack=%b exp 1/7/a5a5a5a5/0/0",
                     bus.rf_RegWrite, bus.rf_WriteReg, bus.rf_WriteData, bus.cpu_stall, bus.dbg_ack);
        end
        step(); settle();
        n_checks++;
        if (bus.dbg_ack !== 1'b1) begin n_fail++; $display("FAIL dbg_wr_ack: got %b exp 1", bus.dbg_ack); end
        step();
        bus.dbg_req = 1'b0;
        exp_rf[7] = 32'hA5A5A5A5;
        do_dbg(1'b0, 5'd7, '0, lat, rd);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL dbg_rd_lat: got %0d exp 2", lat); end
        n_checks++;
        if (rd !== exp_rf[7]) begin n_fail++; $display("FAIL dbg_rd_r7: got %h exp %h", rd, exp_rf[7]); end
    endtask

    // Debug write starved by continuous CPU writes; run twice so the second
    // round only forces through on time if the wait counter restarted at zero.
    task automatic test_forced_write();
        int lat;
        logic [DATA_W-1:0] rd, dd;
        for (int round = 0; round < 2; round++) begin
            dd = 32'hC0DE0000 + 32'(round);
            bus.cpu_we = 1'b1; bus.cpu_waddr = 5'd9;
            bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 5'd10; bus.dbg_wdata = dd;
            for (int k = 0; k <= DBG_MAX_WAIT; k++) begin
                bus.cpu_wdata = 32'(k);
                settle();
                n_checks++;
                if (k < DBG_MAX_WAIT) begin
                    if ({bus.cpu_stall, bus.rf_WriteReg, bus.rf_WriteData} !== {1'b0, 5'd9, 32'(k)}) begin
                        n_fail++;
                        $display("FAIL forced_wait r%0d k%0d: got stall=%b reg=%0d data=%h exp 0/9/%h",
                                 round, k, bus.cpu_stall, bus.rf_WriteReg, bus.rf_WriteData, 32'(k));
                    end
                end else begin
                    if ({bus.cpu_stall, bus.rf_RegWrite, bus.rf_WriteReg, bus.rf_WriteData}
                        !== {1'b1, 1'b1, 5'd10, dd}) begin
                        n_fail++;
                        $display("FAIL forced_grant r%0d: got stall=%b we=%b reg=%0d data=%h exp 1/1/10/%h",
                                 round, bus.cpu_stall, bus.rf_RegWrite, bus.rf_WriteReg, bus.rf_WriteData, dd);
                    end
                end
                step();
            end
            // CPU retries its stalled writeback in the ack cycle
            bus.cpu_wdata = 32'h77000000 + 32'(round);
            settle();
            n_checks++;
            if ({bus.dbg_ack, bus.cpu_stall, bus.rf_RegWrite, bus.rf_WriteReg, bus.rf_WriteData}
                !== {1'b1, 1'b0, 1'b1, 5'd9, 32'h77000000 + 32'(round)}) begin
                n_fail++;
                $display("FAIL forced_retry r%0d: got ack=%b stall=%b we=%b reg=%0d data=%h",
                         round, bus.dbg_ack, bus.cpu_stall, bus.rf_RegWrite, bus.rf_WriteReg, bus.rf_WriteData);
            end
            step();
            bus.dbg_req = 1'b0; bus.cpu_we = 1'b0;
            exp_rf[10] = dd;
            exp_rf[9]  = 32'h77000000 + 32'(round);
        end
        do_dbg(1'b0, 5'd9, '0, lat, rd);
        n_checks++;
        if (rd !== exp_rf[9]) begin n_fail++; $display("FAIL forced_read_r9: got %h exp %h", rd, exp_rf[9]); end
        do_dbg(1'b0, 5'd10, '0, lat, rd);
        n_checks++;
        if (rd !== exp_rf[10]) begin n_fail++; $display("FAIL forced_read_r10: got %h exp %h", rd, exp_rf[10]); end
    endtask

    task automatic test_clr_and_dbg();
        int lat;
        logic [DATA_W-1:0] rd;
        bus.clr_req = 1'b1;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 5'd12; bus.dbg_wdata = 32'h5555AAAA;
        settle();
        n_checks++;
        if (bus.rf_RegWrite !== 1'b0) begin n_fail++; $display("FAIL clrdbg_no_dbg_grant: got we=%b exp 0", bus.rf_RegWrite); end
        step();
        bus.clr_req = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            settle();
            n_checks++;
            if ({bus.clr_busy, bus.rf_WriteReg, bus.rf_WriteData, bus.dbg_ack} !== {1'b1, 5'(i), 32'h0, 1'b0}) begin
                n_fail++;
                $display("FAIL clrdbg_clear%0d: got busy=%b reg=%0d data=%h ack=%b",
                         i, bus.clr_busy, bus.rf_WriteReg, bus.rf_WriteData, bus.dbg_ack);
            end
            step();
        end
        model_clear(31);
        settle();
        n_checks++;
        if ({bus.clr_done, bus.rf_RegWrite, bus.rf_WriteReg, bus.rf_WriteData} !== {1'b1, 1'b1, 5'd12, 32'h5555AAAA}) begin
            n_fail++;
            $display("FAIL clrdbg_after: got done=%b we=%b reg=%0d data=%h exp 1/1/12/5555aaaa",
                     bus.clr_done, bus.rf_RegWrite, bus.rf_WriteReg, bus.rf_WriteData);
        end
        step(); settle();
        n_checks++;
        if (bus.dbg_ack !== 1'b1) begin n_fail++; $display("FAIL clrdbg_ack: got %b exp 1", bus.dbg_ack); end
        step();
        bus.dbg_req = 1'b0;
        exp_rf[12] = 32'h5555AAAA;
        do_dbg(1'b0, 5'd12, '0, lat, rd);
        n_checks++;
        if (rd !== exp_rf[12]) begin n_fail++; $display("FAIL clrdbg_read: got %h exp %h", rd, exp_rf[12]); end
    endtask

    task automatic test_reset_mid_clear();
        int hit, done_seen;
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        hit = -1;
        for (int i = 1; i <= 40; i++) begin
            settle();
            if (bus.clr_busy && bus.rf_WriteReg == 5'd10) begin hit = i; break; end
            step();
        end
        n_checks++;
        if (hit !== 10) begin n_fail++; $display("FAIL midclr_reach10: got cycle %0d exp 10", hit); end
        startin = 1'b1;
        #1;
        n_checks++;
        if ({bus.fsm_state, bus.clr_busy, bus.cpu_stall, bus.rf_RegWrite} !== {IDLE, 3'b000}) begin
            n_fail++;
            $display("FAIL midclr_abort: got state=%0d busy=%b stall=%b we=%b exp idle/0/0/0",
                     bus.fsm_state, bus.clr_busy, bus.cpu_stall, bus.rf_RegWrite);
        end
        model_clear(9);
        step();
        startin = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            if (bus.clr_done) done_seen++;
            step();
        end
        n_checks++;
        if (done_seen !== 0) begin n_fail++; $display("FAIL midclr_no_done: got %0d pulses exp 0", done_seen); end
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        settle();
        n_checks++;
        if ({bus.clr_busy, bus.rf_WriteReg} !== {1'b1, 5'd1}) begin
            n_fail++; $display("FAIL midclr_restart: got busy=%b reg=%0d exp 1/1", bus.clr_busy, bus.rf_WriteReg);
        end
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(); settle();
            if (bus.clr_done) begin done_seen = i + 2; break; end
        end
        // restart cycle was write 1, so done lands 31 cycles after it
        n_checks++;
        if (done_seen !== 32) begin n_fail++; $display("FAIL midclr_full_run: got done at %0d exp 32", done_seen); end
        model_clear(31);
        step();
    endtask

    task automatic test_dbg_r0();
        int lat;
        logic [DATA_W-1:0] rd;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 5'd0; bus.dbg_wdata = 32'hFFFFFFFF;
        settle();
        n_checks++;
        if ({bus.rf_RegWrite, bus.cpu_stall} !== 2'b00) begin
            n_fail++; $display("FAIL dbg_r0_nowrite: got we=%b stall=%b exp 0/0", bus.rf_RegWrite, bus.cpu_stall);
        end
        step(); settle();
        n_checks++;
        if (bus.dbg_ack !== 1'b1) begin n_fail++; $display("FAIL dbg_r0_ack: got %b exp 1", bus.dbg_ack); end
        step();
        bus.dbg_req = 1'b0;
        do_dbg(1'b0, 5'd0, '0, lat, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL dbg_r0_read: got %h exp 0", rd); end
    endtask

    // CPU write to the register being read, landing in the accept cycle:
    // the read returns the value from before that write.
    task automatic test_read_write_race();
        int lat;
        logic [DATA_W-1:0] rd;
        exp_q.push_back(exp_rf[7]);
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 5'd7;
        bus.cpu_we = 1'b1; bus.cpu_waddr = 5'd7; bus.cpu_wdata = 32'h0BADF00D;
        step();
        bus.cpu_we = 1'b0;
        exp_rf[7] = 32'h0BADF00D;
        lat = -1; rd = '0;
        for (int i = 1; i < 16; i++) begin
            settle();
            if (bus.dbg_ack) begin lat = i; rd = bus.dbg_rdata; break; end
            step();
        end
        step();
        bus.dbg_req = 1'b0;
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL race_lat: got %0d exp 2", lat); end
        n_checks++;
        if (rd !== exp_q[0]) begin n_fail++; $display("FAIL race_prewrite: got %h exp %h", rd, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_random();
        int lat, op;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d, rd;
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 2));
            a  = 5'($urandom_range(0, 31));
            d  = $urandom;
            if (op == 0) begin
                bus.cpu_we = 1'b1; bus.cpu_waddr = a; bus.cpu_wdata = d;
                settle();
                n_checks++;
                if (bus.rf_RegWrite !== (a != 5'd0)) begin
                    n_fail++; $display("FAIL rnd_cpu_we it%0d: got %b exp %b", it, bus.rf_RegWrite, (a != 5'd0));
                end
                if (a != 5'd0) begin
                    n_checks++;
                    if ({bus.rf_WriteReg, bus.rf_WriteData} !== {a, d}) begin
                        n_fail++;
                        $display("FAIL rnd_cpu_port it%0d: got reg=%0d data=%h exp %0d/%h",
                                 it, bus.rf_WriteReg, bus.rf_WriteData, a, d);
                    end
                    exp_rf[a] = d;
                end
                step();
                bus.cpu_we = 1'b0;
            end else if (op == 1) begin
                do_dbg(1'b1, a, d, lat, rd);
                n_checks++;
                if (lat !== 1) begin n_fail++; $display("FAIL rnd_dbg_wr_lat it%0d: got %0d exp 1", it, lat); end
            end else begin
                exp_q.push_back(exp_rf[a]);
                do_dbg(1'b0, a, '0, lat, rd);
                n_checks++;
                if (lat !== 2) begin n_fail++; $display("FAIL rnd_dbg_rd_lat it%0d: got %0d exp 2", it, lat); end
                n_checks++;
                if (rd !== exp_q[0]) begin
                    n_fail++; $display("FAIL rnd_dbg_rd it%0d r%0d: got %h exp %h", it, a, rd, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int r = 0; r < NREG; r++) exp_rf[r] = '0;
        bus.rf_val = '0;
        test_reset();
        test_clear();
        test_cpu_write();
        test_dbg_write_read();
        test_forced_write();
        test_clr_and_dbg();
        test_reset_mid_clear();
        test_dbg_r0();
        test_read_write_race();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_access_ctrl.md
Name: rf_access_ctrl

Overview:
Owner of the RegisterFile write port and its regNo debug-read path. Shares the single write port between CPU writeback, a debug/loader host and a built-in clear sequencer that zeroes r1..r31. Sits between the datapath writeback mux and RegisterFile. Asserts cpu_stall whenever the CPU loses the port.

Parameters:
DATA_W, 32, register width
ADDR_W, 5, register address width (32 registers, r0 hard-wired zero)
DBG_MAX_WAIT, 8, cycles a pending debug write may be blocked by CPU writes before it is forced through

Ports:
clk  input  1  system clock, rising edge
startin  input  1  reset, asynchronous, active-high
cpu_we  input  1  CPU writeback enable (RegWrite from control)
cpu_waddr  input  ADDR_W  CPU destination register
cpu_wdata  input  DATA_W  CPU writeback data
cpu_stall  output  1  CPU must hold PC and retry its writeback this cycle
dbg_req  input  1  debug request, level, held until dbg_ack
dbg_we  input  1  1 = write, 0 = read; stable while dbg_req
dbg_addr  input  ADDR_W  debug register address; stable while dbg_req
dbg_wdata  input  DATA_W  debug write data
dbg_ack  output  1  one-cycle completion pulse
dbg_rdata  output  DATA_W  read data, valid with dbg_ack on reads
clr_req  input  1  start clear sequence (sampled in IDLE)
clr_busy  output  1  clear sequence running
clr_done  output  1  one-cycle pulse after last clear write
rf_RegWrite  output  1  to RegisterFile RegWrite
rf_WriteReg  output  ADDR_W  to RegisterFile WriteReg
rf_WriteData  output  DATA_W  to RegisterFile WriteData
rf_regNo  output  ADDR_W  to RegisterFile regNo
rf_val  input  DATA_W  from RegisterFile val

Behaviour:
- Reset (startin=1, asynchronous): state IDLE; clr_cnt=1; wait_cnt=0; dbg_ack=0, dbg_rdata=0, clr_done=0. Combinational outputs follow from IDLE with no grant. Reset mid-clear aborts the sequence with no clr_done; reset mid-debug drops the request with no ack.
- States: IDLE, CLEAR, DBG_RD, ACK.
- Write-port mux is combinational, same cycle as grant. The RegisterFile writes on the next rising edge.
- Priority in IDLE: clr_req > forced debug write > CPU write > debug write.
- IDLE, clr_req=1 -> CLEAR next cycle. The current cycle's CPU write is still granted.
- CLEAR: rf_RegWrite=1, rf_WriteReg=clr_cnt, rf_WriteData=0, cpu_stall=1, clr_busy=1.
  - clr_cnt increments each cycle. At clr_cnt=31 -> IDLE with clr_cnt=1, and clr_done=1 for the first IDLE cycle.
  - Exactly 31 write cycles; r0 is never written.
  - clr_req and dbg_req are ignored during CLEAR; a pending dbg_req is served afterwards.
- CPU write: granted when IDLE, no clr_req and no forced debug. Address 0 gives rf_RegWrite=0 without a stall. cpu_stall=0 unless CLEAR or forced debug.
- Debug write (dbg_req & dbg_we, IDLE):
  - Granted when cpu_we=0, or when wait_cnt==DBG_MAX_WAIT (forced: cpu_stall=1 that cycle).
  - Grant cycle drives the write, except dbg_addr=0, which performs no write but is still acked.
  - Next state ACK: dbg_ack=1 for one cycle, wait_cnt=0. No new debug grant in ACK; CPU writes are allowed in ACK.
  - wait_cnt increments, saturating at DBG_MAX_WAIT, each cycle a debug write is pending and blocked by cpu_we.
- Debug read (dbg_req & !dbg_we, IDLE, no clr_req):
  - rf_regNo=dbg_addr is driven continuously, default 0. The read does not use the write port and never stalls the CPU.
  - Accept -> DBG_RD (1 cycle). At the end of DBG_RD, register dbg_rdata<=rf_val, then enter ACK with dbg_ack=1.
  - Read latency is 2 cycles from accept to ack.
  - Read returns the pre-write value if a CPU write to the same register lands in the accept cycle. This is documented, not a bug.
- ACK -> IDLE unconditionally. The requester must drop dbg_req in the ack cycle; a req still high in IDLE starts a new transaction.
- Outputs dbg_ack, dbg_rdata and clr_done are registered. cpu_stall, clr_busy and the rf_* outputs are combinational from state and inputs.

Decomposition:
- Shared package holds: state encoding (IDLE, CLEAR, DBG_RD, ACK as 2-bit localparams), REG_ZERO=0, LAST_REG=31.
- One natural sub-module, rf_wport_mux: a combinational 3-source priority mux that produces rf_RegWrite, rf_WriteReg and rf_WriteData from grant one-hots.
- FSM and counters stay in rf_access_ctrl.

Test Plan:
- Reset then clr_req pulse: 31 cycles of rf_RegWrite=1, rf_WriteReg 1..31, rf_WriteData=0, cpu_stall=1, clr_busy=1; clr_done pulse next cycle; a readback of r5 preloaded with 0xDEADBEEF returns 0.
- cpu_we=1, cpu_waddr=3, cpu_wdata=0x12345678 in IDLE -> same-cycle rf_WriteReg=3, no stall; cpu_waddr=0 -> rf_RegWrite=0.
- Debug write r7=0xA5A5A5A5 with cpu_we=0 -> written in grant cycle, dbg_ack next cycle; debug read of r7 -> dbg_ack 2 cycles after accept with dbg_rdata=0xA5A5A5A5.
- Debug write held while cpu_we=1 continuously -> grant on cycle DBG_MAX_WAIT+1 with cpu_stall=1 for exactly that cycle; CPU write retried next cycle; wait_cnt back to 0.
- dbg_req and clr_req asserted together -> clear runs first; debug completes after clr_done. startin asserted at clr_cnt=10 -> immediate IDLE, no clr_done; next clr_req restarts at r1.
- Debug write to r0 -> dbg_ack with no RF write; r0 reads 0.
